// File: rtl/cv32e40s_pkg.sv
// Shared types for the instruction-fetch path: fetch source identifiers and
// the upper bound on outstanding fetch transactions.
package cv32e40s_pkg;

    typedef enum logic {
        IFETCH_SRC_R0 = 1'b0,
        IFETCH_SRC_R1 = 1'b1
    } ifetch_src_e;

    localparam int unsigned IFETCH_MAX_OUTSTANDING_MAX = 4;

endpackage

// File: rtl/cv32e40s_ifetch_src_fifo.sv
// In-order FIFO of fetch source IDs; its occupancy doubles as the count of
// accepted-but-unanswered instruction transactions.
module cv32e40s_ifetch_src_fifo
    import cv32e40s_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  ifetch_src_e      push_src_i,
    input  logic             pop_i,
    output ifetch_src_e      head_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    ifetch_src_e      mem_q [DEPTH];
    ifetch_src_e      mem_d [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    // Pointers wrap modulo DEPTH so non-power-of-two depths work too.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    always_comb begin
        push_ok  = push_i & (~full_o | pop_i);
        pop_ok   = pop_i & ~empty_o;
        wr_ptr_d = push_ok ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        mem_d    = mem_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_src_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entries are only read when valid, so storage needs no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/cv32e40s_ifetch_arbiter.sv
// Shares the instruction OBI transaction channel between the prefetcher (R0)
// and the auxiliary pointer fetch (R1), routing in-order responses back.
module cv32e40s_ifetch_arbiter
    import cv32e40s_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned STARVE_LIMIT    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        r0_trans_valid_i,
    output logic        r0_trans_ready_o,
    input  logic [31:0] r0_trans_addr_i,
    input  logic        r1_trans_valid_i,
    output logic        r1_trans_ready_o,
    input  logic [31:0] r1_trans_addr_i,
    output logic        trans_valid_o,
    input  logic        trans_ready_i,
    output logic [31:0] trans_addr_o,
    input  logic        resp_valid_i,
    output logic        r0_resp_valid_o,
    output logic        r1_resp_valid_o,
    output logic [2:0]  outstanding_o,
    output logic        busy_o,
    output logic        protocol_err_o
);

    localparam int unsigned CNT_W    = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_SAT = STARVE_W'(STARVE_LIMIT);

    if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > IFETCH_MAX_OUTSTANDING_MAX
        || STARVE_LIMIT < 1) begin : g_bad_param
        $error("cv32e40s_ifetch_arbiter: illegal parameter value");
    end

    logic                lock_q, lock_d;
    ifetch_src_e         lock_src_q, lock_src_d;
    logic [31:0]         lock_addr_q, lock_addr_d;
    logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;

    logic                lock_hold;
    ifetch_src_e         gnt_src;
    logic                gnt_req;
    logic                accept;
    logic                fifo_pop;
    logic                fifo_empty;
    logic                fifo_full;
    ifetch_src_e         fifo_head;
    logic [CNT_W-1:0]    fifo_count;

    always_comb begin
        lock_hold = lock_q & ((lock_src_q == IFETCH_SRC_R0) ? r0_trans_valid_i
                                                            : r1_trans_valid_i);
        gnt_req   = r0_trans_valid_i | r1_trans_valid_i;
        gnt_src   = IFETCH_SRC_R0;
        if (lock_hold) begin
            gnt_src = lock_src_q;
        end else if (r1_trans_valid_i && (!r0_trans_valid_i || starve_cnt_q == STARVE_SAT)) begin
            gnt_src = IFETCH_SRC_R1;
        end

        trans_valid_o = gnt_req & ~fifo_full;
        trans_addr_o  = '0;
        if (trans_valid_o) begin
            if (lock_hold) begin
                trans_addr_o = lock_addr_q;
            end else begin
                trans_addr_o = (gnt_src == IFETCH_SRC_R1) ? r1_trans_addr_i : r0_trans_addr_i;
            end
        end

        accept           = trans_valid_o & trans_ready_i;
        r0_trans_ready_o = accept & (gnt_src == IFETCH_SRC_R0);
        r1_trans_ready_o = accept & (gnt_src == IFETCH_SRC_R1);

        // A stalled request must be re-presented unchanged on the next cycle.
        lock_d      = trans_valid_o & ~trans_ready_i;
        lock_src_d  = gnt_src;
        lock_addr_d = trans_addr_o;

        starve_cnt_d = starve_cnt_q;
        if (!r1_trans_valid_i || r1_trans_ready_o) begin
            starve_cnt_d = '0;
        end else if (r0_trans_ready_o && starve_cnt_q != STARVE_SAT) begin
            starve_cnt_d = starve_cnt_q + STARVE_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_q       <= 1'b0;
            lock_src_q   <= IFETCH_SRC_R0;
            starve_cnt_q <= '0;
        end else begin
            lock_q       <= lock_d;
            lock_src_q   <= lock_src_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // Only consulted while lock_q is set, so no reset required.
    always_ff @(posedge clk) begin
        lock_addr_q <= lock_addr_d;
    end

    // A response with nothing outstanding is an error and must not disturb the FIFO.
    assign fifo_pop        = resp_valid_i & ~fifo_empty;
    assign protocol_err_o  = resp_valid_i & fifo_empty;
    assign r0_resp_valid_o = fifo_pop & (fifo_head == IFETCH_SRC_R0);
    assign r1_resp_valid_o = fifo_pop & (fifo_head == IFETCH_SRC_R1);
    assign outstanding_o   = 3'(fifo_count);
    assign busy_o          = ~fifo_empty;

    cv32e40s_ifetch_src_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_src_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (accept),
        .push_src_i (gnt_src),
        .pop_i      (fifo_pop),
        .head_o     (fifo_head),
        .empty_o    (fifo_empty),
        .full_o     (fifo_full),
        .count_o    (fifo_count)
    );

endmodule
